sc_speedtick_generator: RTL and testbench
=========================================

Name: sc_speedtick_generator

Overview:
Downstream consumer of the up speed counter's level bus in the Frogger datapath. Converts the current speed level into a periodic one-clock movement tick for lane objects (cars, logs). A higher level gives a shorter period. The period is floored at a minimum so very high levels never stall or alias.

Parameters:
SPEEDTICK_SPEEDWIDTH, 8, width of the speed-level input (matches the up speed counter data width)
SPEEDTICK_PERIODWIDTH, 26, width of the period register and down-counter
SPEEDTICK_BASE_PERIOD, 25000000, period in clocks at level 0
SPEEDTICK_STEP, 1000000, clocks removed from the period per level
SPEEDTICK_MIN_PERIOD, 2000000, floor on the period in clocks; must be >= 1

Ports:
SC_SPEEDTICK_CLOCK_50  input  1  system clock, 50 MHz
SC_SPEEDTICK_RESET_InHigh  input  1  asynchronous reset, active-high
SC_SPEEDTICK_speed_InBUS  input  SPEEDTICK_SPEEDWIDTH  current speed level, from the up speed counter data output
SC_SPEEDTICK_enable_InLow  input  1  0 = run, 1 = hold (pause)
SC_SPEEDTICK_CLEAR_InLow  input  1  synchronous restart of the current period, active-low
SC_SPEEDTICK_tick_Out  output  1  one-clock high pulse at each period expiry
SC_SPEEDTICK_period_OutBUS  output  SPEEDTICK_PERIODWIDTH  registered effective period, for debug and display

Behaviour:
- Reset is the only asynchronous path; all other logic is synchronous to the rising clock edge.
- Reset values: period register = BASE_PERIOD; down-counter = BASE_PERIOD-1; tick_Out = 0; FSM = HOLD.
- Period computation:
  - prod = speed*STEP, computed at full width (SPEEDWIDTH+PERIODWIDTH) with no truncation.
  - If prod >= BASE_PERIOD-MIN_PERIOD, period = MIN_PERIOD; otherwise period = BASE_PERIOD-prod.
  - No wrap-around for any speed value.
  - The period register updates every clock, so period_OutBUS lags speed_InBUS by 1 cycle.
- FSM, 2 states:
  - HOLD: counter frozen, tick_Out = 0. Moves to RUN on the first edge that samples enable_InLow = 0.
  - RUN: counter decrements by 1 per clock. Moves to HOLD on an edge that samples enable_InLow = 1; the counter keeps its value.
- Expiry: in RUN with counter == 0:
  - The next edge sets tick_Out = 1 for exactly 1 cycle.
  - The same edge reloads the counter with period-1, using the period register value at that edge.
  - Result: consecutive ticks are exactly `period` clocks apart.
- Speed change mid-count: the current count is not truncated. The new period takes effect at the next reload. The first tick after the change is therefore timed by the old count.
- Clear (CLEAR_InLow = 0 at an edge):
  - counter = period-1, tick_Out = 0, FSM state unchanged.
  - Clear has priority over expiry and over enable.
  - Clear held low keeps the counter pinned and produces no ticks.
- tick_Out is registered (no combinational path from inputs) and is never asserted in HOLD or during reset.
- Reset asserted mid-count returns every register to its reset value immediately, with no pending tick.

Test Plan:
All scenarios use BASE_PERIOD=10, STEP=2, MIN_PERIOD=3, PERIODWIDTH=8.
1. Reset, speed=0, enable_InLow=0 held -> period_OutBUS=10; first tick 11 clocks after enable (1 clock HOLD->RUN plus 10 counts); ticks every 10 clocks thereafter; tick width 1 clock.
2. speed=2 -> period_OutBUS=6 one cycle later; after the in-flight count finishes, ticks every 6 clocks. speed=4 -> 10-8=2 < 3 -> period=3; ticks every 3 clocks.
3. speed=255 -> period_OutBUS=3 (saturated, no wrap); ticks every 3 clocks.
4. Pause: at speed=0, set enable_InLow=1 for 20 clocks after 4 counts, then release -> no ticks while held; next tick exactly 6 running clocks after release.
5. Clear: pulse CLEAR_InLow=0 for 1 clock on the cycle the counter hits 0 -> no tick that cycle; next tick 10 clocks later. Clear with enable_InLow=1 -> counter reloaded, FSM stays HOLD.
6. Reset asserted mid-count (counter=5) -> tick_Out=0, period_OutBUS=10, FSM=HOLD immediately, without a clock edge; after release and enable, timing matches scenario 1.

Source files
------------

// File: rtl/sc_speedtick_generator_if.sv
// Speed-level in / movement-tick out bundle between the speed counter side and the tick generator.
// master drives the level and controls; slave (the generator) returns the tick and effective period.
interface sc_speedtick_generator_if #(
    parameter int SPEEDTICK_SPEEDWIDTH  = 8,
    parameter int SPEEDTICK_PERIODWIDTH = 26
);
    logic [SPEEDTICK_SPEEDWIDTH-1:0]  SC_SPEEDTICK_speed_InBUS;
    logic                             SC_SPEEDTICK_enable_InLow;
    logic                             SC_SPEEDTICK_CLEAR_InLow;
    logic                             SC_SPEEDTICK_tick_Out;
    logic [SPEEDTICK_PERIODWIDTH-1:0] SC_SPEEDTICK_period_OutBUS;

    modport master (
        output SC_SPEEDTICK_speed_InBUS,
        output SC_SPEEDTICK_enable_InLow,
        output SC_SPEEDTICK_CLEAR_InLow,
        input  SC_SPEEDTICK_tick_Out,
        input  SC_SPEEDTICK_period_OutBUS
    );

    modport slave (
        input  SC_SPEEDTICK_speed_InBUS,
        input  SC_SPEEDTICK_enable_InLow,
        input  SC_SPEEDTICK_CLEAR_InLow,
        output SC_SPEEDTICK_tick_Out,
        output SC_SPEEDTICK_period_OutBUS
    );
endinterface

// File: rtl/sc_speedtick_generator.sv
// Turns the current speed level into a periodic one-clock movement tick for lane objects.
// Higher level gives a shorter period, floored at SPEEDTICK_MIN_PERIOD.
module sc_speedtick_generator #(
    parameter int SPEEDTICK_SPEEDWIDTH  = 8,
    parameter int SPEEDTICK_PERIODWIDTH = 26,
    parameter int SPEEDTICK_BASE_PERIOD = 25000000,
    parameter int SPEEDTICK_STEP        = 1000000,
    parameter int SPEEDTICK_MIN_PERIOD  = 2000000
) (
    input  logic                      SC_SPEEDTICK_CLOCK_50,
    input  logic                      SC_SPEEDTICK_RESET_InHigh,
    sc_speedtick_generator_if.slave   bus
);
    localparam int PW     = SPEEDTICK_PERIODWIDTH;
    localparam int PROD_W = SPEEDTICK_SPEEDWIDTH + SPEEDTICK_PERIODWIDTH;

    localparam logic [PROD_W-1:0] BASE_W  = PROD_W'(SPEEDTICK_BASE_PERIOD);
    localparam logic [PROD_W-1:0] STEP_W  = PROD_W'(SPEEDTICK_STEP);
    localparam logic [PROD_W-1:0] FLOOR_W = PROD_W'(SPEEDTICK_BASE_PERIOD - SPEEDTICK_MIN_PERIOD);
    localparam logic [PW-1:0]     BASE_P  = PW'(SPEEDTICK_BASE_PERIOD);
    localparam logic [PW-1:0]     MIN_P   = PW'(SPEEDTICK_MIN_PERIOD);
    localparam logic [PW-1:0]     ONE_P   = PW'(1);

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   period_q, period_d;
    logic [PW-1:0]   cnt_q, cnt_d;
    logic            tick_q, tick_d;
    logic [PROD_W-1:0] prod;

    // Full-width product, so no speed value can wrap into a long period.
    always_comb begin
        prod     = PROD_W'(bus.SC_SPEEDTICK_speed_InBUS) * STEP_W;
        period_d = (prod >= FLOOR_W) ? MIN_P : PW'(BASE_W - prod);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        if (!bus.SC_SPEEDTICK_CLEAR_InLow) begin
            cnt_d = period_q - ONE_P;
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (!bus.SC_SPEEDTICK_enable_InLow) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (bus.SC_SPEEDTICK_enable_InLow) begin
                        state_d = HOLD;
                    end else if (cnt_q == '0) begin
                        // Reload with period-1 so ticks land exactly `period` clocks apart.
                        tick_d = 1'b1;
                        cnt_d  = period_q - ONE_P;
                    end else begin
                        cnt_d = cnt_q - ONE_P;
                    end
                end
                default: state_d = HOLD;
            endcase
        end
    end

    always_ff @(posedge SC_SPEEDTICK_CLOCK_50 or posedge SC_SPEEDTICK_RESET_InHigh) begin
        if (SC_SPEEDTICK_RESET_InHigh) begin
            state_q  <= HOLD;
            period_q <= BASE_P;
            cnt_q    <= BASE_P - ONE_P;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
        end
    end

    assign bus.SC_SPEEDTICK_tick_Out      = tick_q;
    assign bus.SC_SPEEDTICK_period_OutBUS = period_q;
endmodule

// File: tb/tb_sc_speedtick_generator.sv
// Directed bench for the speed tick generator with BASE=10, STEP=2, MIN=3, 8-bit period.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_sc_speedtick_generator;
    logic clk;
    logic rst;
    int   check_count;
    int   pass_count;
    int   n;

    sc_speedtick_generator_if #(
        .SPEEDTICK_SPEEDWIDTH (8),
        .SPEEDTICK_PERIODWIDTH(8)
    ) bus ();

    sc_speedtick_generator #(
        .SPEEDTICK_SPEEDWIDTH (8),
        .SPEEDTICK_PERIODWIDTH(8),
        .SPEEDTICK_BASE_PERIOD(10),
        .SPEEDTICK_STEP       (2),
        .SPEEDTICK_MIN_PERIOD (3)
    ) dut (
        .SC_SPEEDTICK_CLOCK_50    (clk),
        .SC_SPEEDTICK_RESET_InHigh(rst),
        .bus                      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until tick is seen high, or -1 if the budget runs out.
    task automatic wait_tick(input int limit, output int edges);
        edges = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (bus.SC_SPEEDTICK_tick_Out === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        check_count++;
        if (got !== exp) $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        else pass_count++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.SC_SPEEDTICK_speed_InBUS  = 8'd0;
        bus.SC_SPEEDTICK_enable_InLow = 1'b1;
        bus.SC_SPEEDTICK_CLEAR_InLow  = 1'b1;
        step();
        step();
        check_count++;
        if (bus.SC_SPEEDTICK_tick_Out !== 1'b0) $display("[TB] FAIL reset_tick: got %b, expected 0", bus.SC_SPEEDTICK_tick_Out);
        else pass_count++;
        check_count++;
        if (bus.SC_SPEEDTICK_period_OutBUS !== 8'd10) $display("[TB] FAIL reset_period: got %0d, expected 10", bus.SC_SPEEDTICK_period_OutBUS);
        else pass_count++;
        rst = 1'b0;
    endtask

    task automatic test_base_period();
        bus.SC_SPEEDTICK_enable_InLow = 1'b0;
        wait_tick(40, n);
        check_int("first_tick_latency", n, 11);
        step();
        check_count++;
        if (bus.SC_SPEEDTICK_tick_Out !== 1'b0) $display("[TB] FAIL tick_width: got %b, expected 0", bus.SC_SPEEDTICK_tick_Out);
        else pass_count++;
        // One of the ten edges was spent on the width check above.
        wait_tick(40, n);
        check_int("base_period_a", n, 9);
        wait_tick(40, n);
        check_int("base_period_b", n, 10);
    endtask

    task automatic test_speed_change();
        bus.SC_SPEEDTICK_speed_InBUS = 8'd2;
        step();
        check_int("period_speed2", int'(bus.SC_SPEEDTICK_period_OutBUS), 6);
        wait_tick(40, n);
        check_int("inflight_old_count", n, 9);
        wait_tick(40, n);
        check_int("period6_ticks", n, 6);
        bus.SC_SPEEDTICK_speed_InBUS = 8'd4;
        step();
        check_int("period_speed4_floor", int'(bus.SC_SPEEDTICK_period_OutBUS), 3);
        wait_tick(40, n);
        check_int("inflight_after_speed4", n, 5);
        wait_tick(40, n);
        check_int("period3_ticks", n, 3);
    endtask

    task automatic test_saturation();
        logic [7:0] speeds [6];
        int         exps   [6];
        speeds = '{8'd0, 8'd1, 8'd3, 8'd4, 8'd128, 8'd255};
        exps   = '{10, 8, 4, 3, 3, 3};
        for (int i = 0; i < 6; i++) begin
            bus.SC_SPEEDTICK_speed_InBUS = speeds[i];
            step();
            check_int($sformatf("period_speed%0d", speeds[i]), int'(bus.SC_SPEEDTICK_period_OutBUS), exps[i]);
        end
        wait_tick(40, n);
        wait_tick(40, n);
        check_int("sat_ticks_a", n, 3);
        wait_tick(40, n);
        check_int("sat_ticks_b", n, 3);
    endtask

    task automatic test_pause();
        int ticks_seen;
        bus.SC_SPEEDTICK_speed_InBUS = 8'd0;
        wait_tick(40, n);
        check_int("resync_tick_found", int'(n > 0), 1);
        ticks_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.SC_SPEEDTICK_tick_Out === 1'b1) ticks_seen++;
        end
        bus.SC_SPEEDTICK_enable_InLow = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.SC_SPEEDTICK_tick_Out === 1'b1) ticks_seen++;
        end
        check_int("pause_no_ticks", ticks_seen, 0);
        // 1 edge to re-enter RUN, then 5 decrements from 5 and the expiry edge.
        bus.SC_SPEEDTICK_enable_InLow = 1'b0;
        wait_tick(40, n);
        check_int("resume_tick", n, 7);
    endtask

    task automatic test_clear();
        int ticks_seen;
        for (int i = 0; i < 9; i++) step();
        bus.SC_SPEEDTICK_CLEAR_InLow = 1'b0;
        step();
        bus.SC_SPEEDTICK_CLEAR_InLow = 1'b1;
        check_count++;
        if (bus.SC_SPEEDTICK_tick_Out !== 1'b0) $display("[TB] FAIL clear_beats_expiry: got %b, expected 0", bus.SC_SPEEDTICK_tick_Out);
        else pass_count++;
        wait_tick(40, n);
        check_int("after_clear_tick", n, 10);
        bus.SC_SPEEDTICK_CLEAR_InLow = 1'b0;
        ticks_seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.SC_SPEEDTICK_tick_Out === 1'b1) ticks_seen++;
        end
        check_int("clear_held_no_ticks", ticks_seen, 0);
        bus.SC_SPEEDTICK_CLEAR_InLow = 1'b1;
        wait_tick(40, n);
        check_int("clear_release_tick", n, 10);
        bus.SC_SPEEDTICK_enable_InLow = 1'b1;
        step();
        step();
        bus.SC_SPEEDTICK_CLEAR_InLow = 1'b0;
        step();
        bus.SC_SPEEDTICK_CLEAR_InLow = 1'b1;
        ticks_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.SC_SPEEDTICK_tick_Out === 1'b1) ticks_seen++;
        end
        check_int("clear_in_hold_no_ticks", ticks_seen, 0);
        bus.SC_SPEEDTICK_enable_InLow = 1'b0;
        wait_tick(40, n);
        check_int("clear_in_hold_reload", n, 11);
    endtask

    task automatic test_reset_midcount();
        int ticks_seen;
        bus.SC_SPEEDTICK_speed_InBUS = 8'd2;
        wait_tick(40, n);
        wait_tick(40, n);
        // tick is high and the counter was just reloaded with 5 from period 6.
        check_int("pre_reset_period", int'(bus.SC_SPEEDTICK_period_OutBUS), 6);
        #2;
        rst = 1'b1;
        bus.SC_SPEEDTICK_speed_InBUS  = 8'd0;
        bus.SC_SPEEDTICK_enable_InLow = 1'b1;
        #1;
        check_int("async_reset_tick", int'(bus.SC_SPEEDTICK_tick_Out), 0);
        check_int("async_reset_period", int'(bus.SC_SPEEDTICK_period_OutBUS), 10);
        step();
        rst = 1'b0;
        ticks_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.SC_SPEEDTICK_tick_Out === 1'b1) ticks_seen++;
        end
        check_int("post_reset_hold", ticks_seen, 0);
        bus.SC_SPEEDTICK_enable_InLow = 1'b0;
        wait_tick(40, n);
        check_int("post_reset_first_tick", n, 11);
        wait_tick(40, n);
        check_int("post_reset_period", n, 10);
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        test_reset();
        test_base_period();
        test_speed_change();
        test_saturation();
        test_pause();
        test_clear();
        test_reset_midcount();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
